// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared state, digit type and digit moduli for the stopwatch core.
package stopwatch_pkg;
    typedef enum logic [1:0] {IDLE, RUN, PAUSE, LAP} state_e;
    typedef logic [3:0] bcd_t;
    localparam int DIG_MOD_LO       = 10;
    localparam int DIG_MOD_SEC_TENS = 6;
endpackage

// File: rtl/stopwatch_core_bcd_digit.sv
// bcd_digit: one mod-N BCD digit of the ripple chain; carry_out is combinational.
module bcd_digit
    import stopwatch_pkg::*;
#(
    parameter int N = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output bcd_t q,
    output logic carry_out
);
    localparam bcd_t TOP = bcd_t'(N - 1);

    assign carry_out = inc & (q == TOP);

    always_ff @(posedge clk) begin
        if (rst || clr) q <= '0;
        else if (inc) q <= carry_out ? '0 : q + 4'd1;
    end
endmodule

// File: rtl/stopwatch_core.sv
// stopwatch_core: button edge detect, run/pause/lap FSM, 10 ms prescaler,
// SS.cc BCD counter and lap snapshot feeding the display multiplexer.
module stopwatch_core
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV = 500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_ss,
    input  logic       btn_lap,
    output logic [3:0] cnt0,
    output logic [3:0] cnt1,
    output logic [3:0] cnt2,
    output logic [3:0] cnt3,
    output logic       running,
    output logic       lap_active,
    output logic       ovf
);
    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PSC_TOP = PW'(TICK_DIV - 1);

    state_e        state_q, state_d;
    logic          ss_hist_q, lap_hist_q;
    logic [PW-1:0] psc_q, psc_d;
    bcd_t          snap_q [4];
    bcd_t          live [4];
    logic          running_q, lap_active_q, ovf_q;
    logic          ss_p, lap_p, counting, tick, clr;
    logic [3:0]    inc, carry;

    // ss wins a simultaneous press, so the lap press is masked here
    assign ss_p     = btn_ss & ~ss_hist_q;
    assign lap_p    = btn_lap & ~lap_hist_q & ~ss_p;
    assign counting = (state_q == RUN) || (state_q == LAP);
    assign tick     = counting && (psc_q == PSC_TOP);
    assign clr      = (state_q == PAUSE) && (state_d == IDLE);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = ss_p ? RUN : IDLE;
            RUN:     state_d = ss_p ? PAUSE : lap_p ? LAP : RUN;
            PAUSE:   state_d = ss_p ? RUN : lap_p ? IDLE : PAUSE;
            default: state_d = ss_p ? PAUSE : lap_p ? RUN : LAP;
        endcase
    end

    // PAUSE holds the partial tick; leaving or entering IDLE restarts it
    assign psc_d = (state_q == IDLE || state_d == IDLE) ? '0 :
                   !counting ? psc_q :
                   tick ? '0 : psc_q + PW'(1);

    assign inc = {carry[2:0], tick};

    for (genvar i = 0; i < 4; i++) begin : g_dig
        bcd_digit #(.N(i == 3 ? DIG_MOD_SEC_TENS : DIG_MOD_LO)) u_dig (
            .clk      (clk),
            .rst      (rst),
            .clr      (clr),
            .inc      (inc[i]),
            .q        (live[i]),
            .carry_out(carry[i])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            ss_hist_q    <= 1'b0;
            lap_hist_q   <= 1'b0;
            psc_q        <= '0;
            snap_q       <= '{default: '0};
            running_q    <= 1'b0;
            lap_active_q <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            ss_hist_q    <= btn_ss;
            lap_hist_q   <= btn_lap;
            psc_q        <= psc_d;
            running_q    <= (state_d == RUN) || (state_d == LAP);
            lap_active_q <= state_d == LAP;
            ovf_q        <= carry[3];
            if (state_q == RUN && state_d == LAP) snap_q <= live;
        end
    end

    assign cnt0       = lap_active_q ? snap_q[0] : live[0];
    assign cnt1       = lap_active_q ? snap_q[1] : live[1];
    assign cnt2       = lap_active_q ? snap_q[2] : live[2];
    assign cnt3       = lap_active_q ? snap_q[3] : live[3];
    assign running    = running_q;
    assign lap_active = lap_active_q;
    assign ovf        = ovf_q;
endmodule

// File: tb/tb_stopwatch_core.sv
// tb_stopwatch_core: directed stimulus with a cycle-stamped expectation queue
// drained by an independent monitor at the falling edge.
module tb_stopwatch_core;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_ss = 1'b0;
    logic       btn_lap = 1'b0;
    logic [3:0] cnt0, cnt1, cnt2, cnt3;
    logic       running, lap_active, ovf;

    stopwatch_core #(.TICK_DIV(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_ss    (btn_ss),
        .btn_lap   (btn_lap),
        .cnt0      (cnt0),
        .cnt1      (cnt1),
        .cnt2      (cnt2),
        .cnt3      (cnt3),
        .running   (running),
        .lap_active(lap_active),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          at;
        string       nm;
        logic [15:0] cnt;
        logic        run;
        logic        lap;
        logic        ov;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    always @(negedge clk) begin
        exp_t e;
        while (sb.size() != 0 && sb[0].at <= cyc) begin
            e = sb.pop_front();
            checks++;
            if (e.at != cyc || {cnt3, cnt2, cnt1, cnt0} !== e.cnt || running !== e.run ||
                lap_active !== e.lap || ovf !== e.ov) begin
                errors++;
                $display("FAIL %s @cycle %0d (due %0d): got %h run=%b lap=%b ovf=%b, expected %h run=%b lap=%b ovf=%b",
                         e.nm, cyc, e.at, {cnt3, cnt2, cnt1, cnt0}, running, lap_active, ovf,
                         e.cnt, e.run, e.lap, e.ov);
            end
        end
    end

    task automatic exp(input int at, input string nm, input logic [15:0] c,
                       input logic r, input logic l, input logic o);
        exp_t e;
        e.at = at; e.nm = nm; e.cnt = c; e.run = r; e.lap = l; e.ov = o;
        sb.push_back(e);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic press(input logic s, input logic l);
        btn_ss = s;
        btn_lap = l;
        @(negedge clk);
        btn_ss = 1'b0;
        btn_lap = 1'b0;
    endtask

    task automatic do_reset(input string nm);
        rst = 1'b1;
        btn_ss = 1'b0;
        btn_lap = 1'b0;
        exp(cyc + 1, nm, 16'h0000, 1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int k;
        @(negedge clk);
        do_reset("reset");
        // start, first tick, one second, full-scale wrap
        k = cyc;
        exp(k + 1, "start", 16'h0000, 1, 0, 0);
        exp(k + 4, "pre_first_tick", 16'h0000, 1, 0, 0);
        exp(k + 5, "first_tick", 16'h0001, 1, 0, 0);
        exp(k + 400, "at_0099", 16'h0099, 1, 0, 0);
        exp(k + 401, "one_second", 16'h0100, 1, 0, 0);
        exp(k + 23997, "at_5999", 16'h5999, 1, 0, 0);
        exp(k + 24000, "hold_5999", 16'h5999, 1, 0, 0);
        exp(k + 24001, "wrap_ovf", 16'h0000, 1, 0, 1);
        exp(k + 24002, "ovf_one_cycle", 16'h0000, 1, 0, 0);
        exp(k + 24005, "after_wrap", 16'h0001, 1, 0, 0);
        press(1, 0);
        wait_until(k + 24006);

        do_reset("reset_mid_run");
        // lap freeze and release
        k = cyc;
        exp(k + 31, "lap_enter", 16'h0007, 1, 1, 0);
        exp(k + 100, "lap_frozen", 16'h0007, 1, 1, 0);
        exp(k + 111, "lap_release", 16'h0027, 1, 0, 0);
        exp(k + 113, "live_after_lap", 16'h0028, 1, 0, 0);
        exp(k + 121, "lap_again", 16'h0029, 1, 1, 0);
        press(1, 0);
        wait_until(k + 30);
        press(0, 1);
        wait_until(k + 110);
        press(0, 1);
        wait_until(k + 120);
        press(0, 1);
        wait_until(k + 130);
        do_reset("reset_in_lap");
        k = cyc;
        exp(k + 2, "idle_lap_ignored", 16'h0000, 0, 0, 0);
        press(0, 1);
        wait_until(k + 3);

        do_reset("reset_pause");
        // pause keeps partial tick, clear from pause, simultaneous press
        k = cyc;
        exp(k + 23, "pause", 16'h0005, 0, 0, 0);
        exp(k + 73, "pause_held", 16'h0005, 0, 0, 0);
        exp(k + 75, "resume_partial", 16'h0005, 1, 0, 0);
        exp(k + 76, "resume_tick", 16'h0006, 1, 0, 0);
        exp(k + 81, "pause2", 16'h0007, 0, 0, 0);
        exp(k + 86, "clear", 16'h0000, 0, 0, 0);
        exp(k + 94, "restart_pre_tick", 16'h0000, 1, 0, 0);
        exp(k + 95, "restart_tick", 16'h0001, 1, 0, 0);
        exp(k + 101, "ss_wins", 16'h0002, 0, 0, 0);
        exp(k + 105, "ss_wins_held", 16'h0002, 0, 0, 0);
        press(1, 0);
        wait_until(k + 22);
        press(1, 0);
        wait_until(k + 73);
        press(1, 0);
        wait_until(k + 80);
        press(1, 0);
        wait_until(k + 85);
        press(0, 1);
        wait_until(k + 90);
        press(1, 0);
        wait_until(k + 100);
        press(1, 1);
        wait_until(k + 106);

        // start button held through reset release gives one start only
        rst = 1'b1;
        btn_ss = 1'b1;
        exp(cyc + 1, "held_reset", 16'h0000, 0, 0, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        k = cyc;
        exp(k + 1, "held_start", 16'h0000, 1, 0, 0);
        exp(k + 10, "held_single", 16'h0002, 1, 0, 0);
        exp(k + 22, "held_release", 16'h0005, 1, 0, 0);
        wait_until(k + 20);
        btn_ss = 1'b0;
        wait_until(k + 25);

        for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations unchecked, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
